// File: rtl/ap_ddr_pkg.sv
// Shared definitions for the AP DDR access arbiter: FSM encoding, client
// indices and default DDR command widths.
package ap_ddr_pkg;

  localparam int DDR_ADDR_WIDTH_DEF  = 28;
  localparam int BURST_LEN_WIDTH_DEF = 10;
  localparam int N_RD_DEF            = 3;

  // Read client indices into the rd_* vectors
  localparam int CL_INSTR = 0;
  localparam int CL_DATA  = 1;
  localparam int CL_JMP   = 2;

  typedef logic [2:0] arb_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_BURST = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/ddr_access_arbiter_rr_select.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr (wrapping) wins. With ptr tied to 0 it degenerates to fixed priority.
module rr_select #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found_s;

  // Scan offsets from ptr upward, locking onto the first active request
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        grant[j] = grant[j] | (~found_s & req[j] & (j == ((int'(ptr) + i) % N)));
        found_s  = |grant;
      end
    end
  end

endmodule

// File: rtl/ddr_access_arbiter.sv
// Serialises store and read clients onto the single DDR burst interface.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin among read clients
// (default build is fixed priority, lowest index first).
module ddr_access_arbiter
  import ap_ddr_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH  = DDR_ADDR_WIDTH_DEF,
  parameter int BURST_LEN_WIDTH = BURST_LEN_WIDTH_DEF,
  parameter int N_RD            = N_RD_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_RD-1:0]                 rd_req,
  input  logic [N_RD*DDR_ADDR_WIDTH-1:0]  rd_addr,
  input  logic [N_RD*BURST_LEN_WIDTH-1:0] rd_len,
  input  logic                            wr_req,
  input  logic [DDR_ADDR_WIDTH-1:0]       wr_addr,
  input  logic [BURST_LEN_WIDTH-1:0]      wr_len,
  output logic [N_RD-1:0]                 rd_grant,
  output logic [N_RD-1:0]                 rd_done,
  output logic [N_RD-1:0]                 rd_valid,
  output logic                            wr_grant,
  output logic                            wr_done,
  output logic                            wr_data_req,
  output logic                            mem_rd_req,
  output logic                            mem_wr_req,
  output logic [DDR_ADDR_WIDTH-1:0]       mem_addr,
  output logic [BURST_LEN_WIDTH-1:0]      mem_len,
  input  logic                            mem_ack,
  input  logic                            mem_rd_valid,
  input  logic                            mem_wr_data_req,
  input  logic                            mem_done
);

  localparam int PTR_W = (N_RD > 1) ? $clog2(N_RD) : 1;

  arb_state_t                 state_r;
  arb_state_t                 state_nxt_s;
  logic [N_RD-1:0]            rd_pick_s;
  logic [PTR_W-1:0]           ptr_s;
  logic [DDR_ADDR_WIDTH-1:0]  pick_addr_s;
  logic [BURST_LEN_WIDTH-1:0] pick_len_s;
  logic                       done_enter_s;

  logic [N_RD-1:0]            rd_sel_r;
  logic                       wr_sel_r;
  logic [DDR_ADDR_WIDTH-1:0]  addr_r;
  logic [BURST_LEN_WIDTH-1:0] len_r;
  logic [N_RD-1:0]            rd_grant_r;
  logic                       wr_grant_r;
  logic [N_RD-1:0]            rd_done_r;
  logic                       wr_done_r;
  logic                       mem_rd_req_r;
  logic                       mem_wr_req_r;
  logic [DDR_ADDR_WIDTH-1:0]  mem_addr_r;
  logic [BURST_LEN_WIDTH-1:0] mem_len_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] idx_r;
  logic [PTR_W-1:0] pick_idx_s;

  // Index of the picked read client, kept for the pointer update at DONE
  always_comb begin
    pick_idx_s = '0;
    for (int j = 0; j < N_RD; j++) begin
      pick_idx_s = pick_idx_s | (PTR_W'(j) & {PTR_W{rd_pick_s[j]}});
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = '0;
`endif

  rr_select #(
    .N     (N_RD),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req   (rd_req),
    .ptr   (ptr_s),
    .grant (rd_pick_s)
  );

  // One-hot mux of the picked read client's address and length
  always_comb begin
    pick_addr_s = '0;
    pick_len_s  = '0;
    for (int j = 0; j < N_RD; j++) begin
      pick_addr_s = pick_addr_s | (rd_addr[j*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH] & {DDR_ADDR_WIDTH{rd_pick_s[j]}});
      pick_len_s  = pick_len_s  | (rd_len[j*BURST_LEN_WIDTH +: BURST_LEN_WIDTH] & {BURST_LEN_WIDTH{rd_pick_s[j]}});
    end
  end

  // Next-state decode; mem_ack / mem_done only matter in their own state
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (wr_req || (|rd_req)) state_nxt_s = ST_GRANT;
        else                     state_nxt_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (len_r == '0) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_CMD;
      end
      ST_CMD: begin
        if (mem_ack) state_nxt_s = ST_BURST;
        else         state_nxt_s = ST_CMD;
      end
      ST_BURST: begin
        if (mem_done) state_nxt_s = ST_DONE;
        else          state_nxt_s = ST_BURST;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  assign done_enter_s = ((state_r == ST_GRANT) && (len_r == '0)) ||
                        ((state_r == ST_BURST) && mem_done);

  // FSM state, client selection and registered command/handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      rd_sel_r     <= '0;
      wr_sel_r     <= 1'b0;
      addr_r       <= '0;
      len_r        <= '0;
      rd_grant_r   <= '0;
      wr_grant_r   <= 1'b0;
      rd_done_r    <= '0;
      wr_done_r    <= 1'b0;
      mem_rd_req_r <= 1'b0;
      mem_wr_req_r <= 1'b0;
      mem_addr_r   <= '0;
      mem_len_r    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_r        <= '0;
      idx_r        <= '0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      rd_done_r <= '0;
      wr_done_r <= 1'b0;
      if (done_enter_s) begin
        rd_grant_r <= '0;
        wr_grant_r <= 1'b0;
        rd_done_r  <= rd_sel_r;
        wr_done_r  <= wr_sel_r;
      end
      case (state_r)
        ST_IDLE: begin
          // Store wins over reads so write-back lands before any refill
          if (wr_req) begin
            wr_sel_r   <= 1'b1;
            wr_grant_r <= 1'b1;
            addr_r     <= wr_addr;
            len_r      <= wr_len;
          end else if (|rd_req) begin
            rd_sel_r   <= rd_pick_s;
            rd_grant_r <= rd_pick_s;
            addr_r     <= pick_addr_s;
            len_r      <= pick_len_s;
`ifdef ARB_ROUND_ROBIN_EN
            idx_r      <= pick_idx_s;
`endif
          end
        end
        ST_GRANT: begin
          if (len_r != '0) begin
            mem_rd_req_r <= |rd_sel_r;
            mem_wr_req_r <= wr_sel_r;
            mem_addr_r   <= addr_r;
            mem_len_r    <= len_r;
          end
        end
        ST_CMD: begin
          if (mem_ack) begin
            mem_rd_req_r <= 1'b0;
            mem_wr_req_r <= 1'b0;
          end
        end
        ST_DONE: begin
          rd_sel_r   <= '0;
          wr_sel_r   <= 1'b0;
          mem_addr_r <= '0;
          mem_len_r  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
          if (|rd_sel_r) begin
            if (idx_r == PTR_W'(N_RD - 1)) ptr_r <= '0;
            else                           ptr_r <= idx_r + PTR_W'(1);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_grant   = rd_grant_r;
  assign wr_grant   = wr_grant_r;
  assign rd_done    = rd_done_r;
  assign wr_done    = wr_done_r;
  assign mem_rd_req = mem_rd_req_r;
  assign mem_wr_req = mem_wr_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_len    = mem_len_r;

  // Burst strobes pass straight through to the granted client only
  assign rd_valid    = ((state_r == ST_BURST) && mem_rd_valid) ? rd_grant_r : '0;
  assign wr_data_req = (state_r == ST_BURST) & mem_wr_data_req & wr_grant_r;

endmodule

// File: tb/tb_ddr_access_arbiter.sv
// Directed self-checking bench for ddr_access_arbiter; expectations follow
// the ARB_ROUND_ROBIN_EN build option.
module tb_ddr_access_arbiter;
  import ap_ddr_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_req;
  logic [83:0] rd_addr;
  logic [29:0] rd_len;
  logic        wr_req;
  logic [27:0] wr_addr;
  logic [9:0]  wr_len;
  logic [2:0]  rd_grant;
  logic [2:0]  rd_done;
  logic [2:0]  rd_valid;
  logic        wr_grant;
  logic        wr_done;
  logic        wr_data_req;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [27:0] mem_addr;
  logic [9:0]  mem_len;
  logic        mem_ack;
  logic        mem_rd_valid;
  logic        mem_wr_data_req;
  logic        mem_done;

  int errors = 0;
  int checks = 0;

  ddr_access_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_len          (rd_len),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_len          (wr_len),
    .rd_grant        (rd_grant),
    .rd_done         (rd_done),
    .rd_valid        (rd_valid),
    .wr_grant        (wr_grant),
    .wr_done         (wr_done),
    .wr_data_req     (wr_data_req),
    .mem_rd_req      (mem_rd_req),
    .mem_wr_req      (mem_wr_req),
    .mem_addr        (mem_addr),
    .mem_len         (mem_len),
    .mem_ack         (mem_ack),
    .mem_rd_valid    (mem_rd_valid),
    .mem_wr_data_req (mem_wr_data_req),
    .mem_done        (mem_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one transfer starting from an IDLE cycle whose request is already driven
  task automatic xfer(input string tag, input logic [2:0] er, input logic ew,
                      input logic [27:0] ea, input logic [9:0] el,
                      input int ack_dly, input int beats,
                      input logic drop_cmd, input logic release_req);
    tick();
    chk({tag, ".grant_rd"}, rd_grant, er);
    chk({tag, ".grant_wr"}, wr_grant, ew);
    chk({tag, ".grant_mrd"}, mem_rd_req, 1'b0);
    chk({tag, ".grant_mwr"}, mem_wr_req, 1'b0);
    if (el == 10'd0) begin
      tick();
    end else begin
      tick();
      if (drop_cmd) rd_req = rd_req & ~er;
      for (int c = 1; c <= ack_dly; c++) begin
        chk({tag, ".cmd_mrd"}, mem_rd_req, |er);
        chk({tag, ".cmd_mwr"}, mem_wr_req, ew);
        chk({tag, ".cmd_addr"}, mem_addr, ea);
        chk({tag, ".cmd_len"}, mem_len, el);
        if (c == ack_dly) mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
      end
      chk({tag, ".burst_mrd"}, mem_rd_req, 1'b0);
      chk({tag, ".burst_mwr"}, mem_wr_req, 1'b0);
      chk({tag, ".burst_addr"}, mem_addr, ea);
      for (int b = 0; b < beats; b++) begin
        mem_rd_valid    = 1'b1;
        mem_wr_data_req = 1'b1;
        mem_done        = (b == beats - 1);
        #1;
        chk({tag, ".rd_valid"}, rd_valid, er);
        chk({tag, ".wr_data_req"}, wr_data_req, ew);
        tick();
        mem_rd_valid    = 1'b0;
        mem_wr_data_req = 1'b0;
        mem_done        = 1'b0;
      end
    end
    chk({tag, ".done_rd"}, rd_done, er);
    chk({tag, ".done_wr"}, wr_done, ew);
    chk({tag, ".done_grant_rd"}, rd_grant, 3'b000);
    chk({tag, ".done_grant_wr"}, wr_grant, 1'b0);
    if (release_req) begin
      rd_req = rd_req & ~er;
      if (ew) wr_req = 1'b0;
    end
    tick();
    chk({tag, ".idle_done_rd"}, rd_done, 3'b000);
    chk({tag, ".idle_done_wr"}, wr_done, 1'b0);
  endtask

  initial begin
    logic [27:0] addr_tbl [3];
    logic [2:0]  exp_oh;
    int          idx;

    rst = 1'b0;
    rd_req = 3'b000; rd_addr = 84'd0; rd_len = 30'd0;
    wr_req = 1'b0; wr_addr = 28'd0; wr_len = 10'd0;
    mem_ack = 1'b0; mem_rd_valid = 1'b0; mem_wr_data_req = 1'b0; mem_done = 1'b0;
    tick();
    tick();
    chk("rst.rd_grant", rd_grant, 3'b000);
    chk("rst.wr_grant", wr_grant, 1'b0);
    chk("rst.mem_rd_req", mem_rd_req, 1'b0);
    chk("rst.mem_addr", mem_addr, 28'd0);
    chk("rst.rd_done", rd_done, 3'b000);
    rst = 1'b1;

    addr_tbl[0] = 28'h0000111;
    addr_tbl[1] = 28'h0028000;
    addr_tbl[2] = 28'h0000222;
    for (int k = 0; k < 3; k++) rd_addr[k*28 +: 28] = addr_tbl[k];
    rd_len[0 +: 10]  = 10'd4;
    rd_len[10 +: 10] = 10'd16;
    rd_len[20 +: 10] = 10'd3;

    // Lone data-load read
    tick();
    rd_req = 3'b010;
    xfer("t1", 3'b010, 1'b0, 28'h0028000, 10'd16, 2, 16, 1'b0, 1'b1);

    // Stray ack while idle must not move the FSM
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray.rd_grant", rd_grant, 3'b000);
    chk("stray.mem_rd_req", mem_rd_req, 1'b0);

    // Store and instruction read raised together: store first
    wr_addr = 28'h0ABCDE0; wr_len = 10'd4;
    wr_req = 1'b1; rd_req = 3'b001;
    xfer("t2w", 3'b000, 1'b1, 28'h0ABCDE0, 10'd4, 1, 4, 1'b0, 1'b1);
    xfer("t2r", 3'b001, 1'b0, 28'h0000111, 10'd4, 1, 4, 1'b0, 1'b1);

    // Zero-length store
    wr_len = 10'd0; wr_req = 1'b1;
    xfer("t3z", 3'b000, 1'b1, 28'h0000000, 10'd0, 1, 0, 1'b0, 1'b1);

    // Jump client drops its request during CMD
    rd_req = 3'b100;
    xfer("t4", 3'b100, 1'b0, 28'h0000222, 10'd3, 1, 3, 1'b1, 1'b1);

    // Reset mid-burst
    rd_req = 3'b001;
    rd_len[0 +: 10] = 10'd8;
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rd_valid = 1'b1;
    #1;
    chk("t5.pre_valid", rd_valid, 3'b001);
    rst = 1'b0; rd_req = 3'b000;
    tick();
    chk("t5.rd_valid", rd_valid, 3'b000);
    chk("t5.rd_grant", rd_grant, 3'b000);
    chk("t5.mem_rd_req", mem_rd_req, 1'b0);
    chk("t5.mem_addr", mem_addr, 28'd0);
    chk("t5.mem_len", mem_len, 10'd0);
    rst = 1'b1; mem_rd_valid = 1'b0; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("t5.stray_done", rd_done, 3'b000);
    chk("t5.stray_grant", rd_grant, 3'b000);
    tick();
    chk("t5.stray_done2", rd_done, 3'b000);

    // All reads held for six transfers; pointer starts at 0 after reset
    for (int k = 0; k < 3; k++) rd_len[k*10 +: 10] = 10'd2;
    rd_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = t % 3;
`else
      idx = CL_INSTR;
`endif
      exp_oh = 3'b001 << idx;
      xfer($sformatf("rr%0d", t), exp_oh, 1'b0, addr_tbl[idx], 10'd2, 1, 2, 1'b0, 1'b0);
    end
    rd_req = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_access_arbiter.md
# ddr_access_arbiter

Arbitrates the single DDR burst interface between the four AP memory clients: instruction-cache read, data-cache load, data-cache store and jump-address read. It serialises their requests, drives one burst command at a time to the DDR interface module, and steers burst valid and write-request strobes back to the granted client only. It sits between the caches and the DDR interface module and owns all DDR command sequencing.

## Interface
- DDR_ADDR_WIDTH, 28, DDR byte address width
- BURST_LEN_WIDTH, 10, burst length width, matching the DDR read counter
- N_RD, 3, number of read clients
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- rd_req  in  N_RD  read requests: bit0 instruction read, bit1 DATA_read_req, bit2 JMP_ADDR_read_req; each held high until its done pulse
- rd_addr  in  N_RD*DDR_ADDR_WIDTH  read start address per client
- rd_len  in  N_RD*BURST_LEN_WIDTH  read burst length per client
- wr_req  in  1  DATA_store_req, held high until wr_done
- wr_addr  in  DDR_ADDR_WIDTH  store start address
- wr_len  in  BURST_LEN_WIDTH  store burst length
- rd_grant  out  N_RD  one-hot read grant
- rd_done  out  N_RD  one-cycle completion pulse per read client
- rd_valid  out  N_RD  rd_burst_data_valid steered to the granted client
- wr_grant  out  1  store grant
- wr_done  out  1  one-cycle store completion pulse
- wr_data_req  out  1  wr_burst_data_req gated by wr_grant
- mem_rd_req  out  1  burst read command to the DDR interface
- mem_wr_req  out  1  burst write command to the DDR interface
- mem_addr  out  DDR_ADDR_WIDTH  command address
- mem_len  out  BURST_LEN_WIDTH  command burst length
- mem_ack  in  1  DDR interface accepted the command (one-cycle pulse)
- mem_rd_valid  in  1  read burst data valid
- mem_wr_data_req  in  1  write burst data request
- mem_done  in  1  burst finished (one-cycle pulse)

## Operation
- States: IDLE, GRANT, CMD, BURST, DONE.
- IDLE: if wr_req is high, select the store. Otherwise, if any rd_req bit is high, select a read client by policy. Then go to GRANT. Store always beats reads, so write-back completes before a refill of the same lines.
- GRANT: register the selected client, its address and its length. Assert the grant. If the length is 0, go to DONE with no DDR access. Otherwise go to CMD.
- CMD: hold mem_rd_req or mem_wr_req, together with mem_addr and mem_len, until mem_ack. Then go to BURST.
- BURST: route mem_rd_valid or mem_wr_data_req to the granted client only; all other clients see 0. On mem_done go to DONE.
- DONE: pulse the granted client's done for one cycle, drop the grant, and return to IDLE.
- Grants are one-hot. At most one of rd_grant and wr_grant is set.
- A client that drops its request after GRANT does not abort the transfer. The burst completes and done still pulses.
- mem_ack or mem_done outside the state that expects it is ignored.

## Timing
- Reset (rst low at a clk edge) forces IDLE. All outputs are 0 and the RR pointer is 0. Reset mid-burst abandons the transfer. The DDR interface is reset by the same rst.
- Request sampled in IDLE → grant high on the next edge → mem_*_req high one cycle later.
- Minimum occupancy for a nonzero length with immediate ack and done is 5 cycles, IDLE to IDLE.
- A zero-length request is 3 cycles and produces a done pulse only.
- mem_addr and mem_len are stable from CMD entry until DONE.
- rd_valid and wr_data_req are combinational from the mem_* inputs: zero added latency.
- A request raised during DONE is seen in the following IDLE cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: read clients are served round robin. The pointer advances to the granted index + 1 (mod N_RD) at DONE. Search starts at the pointer.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins (instruction > data load > jump address). No pointer register.
- Store-over-read priority is identical in both builds.

## Structure
- Shared package ap_ddr_pkg holds:
  - the state encoding;
  - the client index constants (CL_INSTR=0, CL_DATA=1, CL_JMP=2);
  - DDR_ADDR_WIDTH and BURST_LEN_WIDTH defaults.
- One sub-module, rr_select: N_RD-bit request vector plus pointer in, one-hot grant out. It is purely combinational. The pointer register lives in the parent.

## Test plan
- Lone rd_req=3'b010, addr 0x0028000, len 16, ack 2 cycles after CMD, done after 16 valids → rd_grant=3'b010, mem_rd_req held 2 cycles, rd_valid[1] only, rd_done=3'b010 once.
- wr_req and rd_req=3'b001 raised on the same cycle → store is served first (wr_done), then the instruction read.
- rd_req=3'b111 held for 6 transfers, RR build → grant order 0,1,2,0,1,2. Fixed-priority build → client 0 six times.
- wr_len=0 → wr_grant then wr_done, mem_wr_req never asserted, 3 cycles total.
- rst low during BURST with valids streaming → next cycle all outputs are 0; an unmatched mem_done after reset causes no done pulse.
- Stray mem_ack in IDLE, and client 2 dropping its request in CMD → no state change for the stray ack; the burst for client 2 completes and rd_done[2] pulses.
